// File: rtl/pipelined_rca.sv
// pipelined_rca
//   Pipelined ripple-carry adder/subtractor. A WIDTH-bit add is split into
//   STAGES slices of SW = WIDTH/STAGES bits, one slice per pipeline stage.
//   The carry between slices is registered. Upper operand slices ride down
//   the pipeline unchanged. Lower sum slices ride along, so all slices of a
//   result leave together.
//   A single global advance (!out_valid || out_ready) moves or holds every stage.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: add, 1: subtract
//   in_valid   operands valid this cycle
//   in_ready   block accepts input this cycle (== advance)
//   sum        WIDTH-bit result (registered)
//   cout       carry-out; in subtract mode 1 means no borrow
//   ovf        signed overflow of the effective addition
//   out_valid  sum/cout/ovf valid
//   out_ready  downstream accepts result

module pipelined_rca #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    // Stage k registers hold the state after slice k has been added.
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    // Inputs presented to stage k and the results it computes.
    logic [WIDTH-1:0] w_a_src  [STAGES];
    logic [WIDTH-1:0] w_b_src  [STAGES];
    logic [WIDTH-1:0] w_s_src  [STAGES];
    logic             w_c_src  [STAGES];
    logic             w_v_src  [STAGES];
    logic [SW:0]      w_add    [STAGES];
    logic [WIDTH-1:0] w_s_next [STAGES];
    logic             w_ovf_next;
    logic             w_adv;

    assign w_adv = !r_v[L] || out_ready;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_a_src[k]  = '0;
            w_b_src[k]  = '0;
            w_s_src[k]  = '0;
            w_c_src[k]  = 1'b0;
            w_v_src[k]  = 1'b0;
            w_add[k]    = '0;
            w_s_next[k] = '0;
        end

        // Subtraction is a + ~b + ~cin, so invert b and the carry once at entry.
        w_a_src[0] = a;
        w_b_src[0] = b ^ {WIDTH{sub}};
        w_c_src[0] = cin ^ sub;
        w_v_src[0] = in_valid;

        for (int k = 1; k < STAGES; k++) begin
            w_a_src[k] = r_a[k-1];
            w_b_src[k] = r_b[k-1];
            w_s_src[k] = r_s[k-1];
            w_c_src[k] = r_c[k-1];
            w_v_src[k] = r_v[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            w_add[k] = {1'b0, w_a_src[k][k*SW +: SW]}
                     + {1'b0, w_b_src[k][k*SW +: SW]}
                     + {{SW{1'b0}}, w_c_src[k]};
            w_s_next[k] = w_s_src[k];
            w_s_next[k][k*SW +: SW] = w_add[k][SW-1:0];
        end

        // The carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
        w_ovf_next = w_add[L][SW]
                   ^ (w_a_src[L][WIDTH-1] ^ w_b_src[L][WIDTH-1] ^ w_add[L][SW-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_src[k];
                r_b[k] <= w_b_src[k];
                r_s[k] <= w_s_next[k];
                r_c[k] <= w_add[k][SW];
                r_v[k] <= w_v_src[k];
            end
            r_ovf <= w_ovf_next;
        end
    end

    assign in_ready  = w_adv;
    assign sum       = r_s[L];
    assign cout      = r_c[L];
    assign ovf       = r_ovf;
    assign out_valid = r_v[L];

endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca
//   Drives two instances of pipelined_rca (8-bit/2-stage and 16-bit/4-stage).
//   Each instance is compared against a queue-based delay model.
//   The model's results are computed with plain integer arithmetic.

module tb_pipelined_rca;

    typedef struct packed {
        logic        v;
        logic [15:0] s;
        logic        c;
        logic        o;
    } ent_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] t_a    [2];
    logic [15:0] t_b    [2];
    logic        t_cin  [2];
    logic        t_sub  [2];
    logic        t_iv   [2];
    logic        t_ordy [2];

    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic        o_ir [2];
    logic        o_co [2];
    logic        o_of [2];
    logic        o_ov [2];
    logic [15:0] o_sum [2];

    assign o_sum[0] = {8'h00, sum8};
    assign o_sum[1] = sum16;

    pipelined_rca #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst),
        .a(t_a[0][7:0]), .b(t_b[0][7:0]), .cin(t_cin[0]), .sub(t_sub[0]),
        .in_valid(t_iv[0]), .in_ready(o_ir[0]),
        .sum(sum8), .cout(o_co[0]), .ovf(o_of[0]),
        .out_valid(o_ov[0]), .out_ready(t_ordy[0])
    );

    pipelined_rca #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst),
        .a(t_a[1]), .b(t_b[1]), .cin(t_cin[1]), .sub(t_sub[1]),
        .in_valid(t_iv[1]), .in_ready(o_ir[1]),
        .sum(sum16), .cout(o_co[1]), .ovf(o_of[1]),
        .out_valid(o_ov[1]), .out_ready(t_ordy[1])
    );

    // Reference model: a slot is pushed on every advance (bubble or real).
    // The front slot is what the DUT must present once the queue holds STAGES slots.
    ent_t q0[$];
    ent_t q1[$];

    function automatic int wid(int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic ent_t ref_op(int w, logic [15:0] av, logic [15:0] bv, logic c, logic s);
        ent_t   e;
        longint m, half, ua, ub, full, sa, sb, ex;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(av) % m;
        ub   = longint'(bv) % m;
        if (s) full = ua - ub - longint'(c) + m;
        else   full = ua + ub + longint'(c);
        sa = (ua >= half) ? ua - m : ua;
        sb = (ub >= half) ? ub - m : ub;
        ex = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
        e.v = 1'b1;
        e.s = 16'(full % m);
        e.c = (full >= m);
        e.o = (ex >= half) || (ex < -half);
        return e;
    endfunction

    function automatic bit exp_valid(int d);
        if (d == 0) return (q0.size() == 2) && q0[0].v;
        return (q1.size() == 4) && q1[0].v;
    endfunction

    function automatic ent_t front(int d);
        if (d == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic push(int d, ent_t e);
        if (d == 0) begin
            q0.push_back(e);
            if (q0.size() > 2) void'(q0.pop_front());
        end else begin
            q1.push_back(e);
            if (q1.size() > 4) void'(q1.pop_front());
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set(int d, logic iv, logic [15:0] av, logic [15:0] bv,
                       logic c, logic s, logic ordy);
        t_iv[d]   = iv;
        t_a[d]    = av;
        t_b[d]    = bv;
        t_cin[d]  = c;
        t_sub[d]  = s;
        t_ordy[d] = ordy;
    endtask

    task automatic idle(int d);
        set(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    // One clock: check in_ready before the edge, update the model, check outputs after.
    task automatic tick();
        bit   adv [2];
        bit   xv;
        ent_t e;
        ent_t f;
        #1;
        for (int d = 0; d < 2; d++) begin
            adv[d] = !exp_valid(d) || t_ordy[d];
            if (!rst) chk($sformatf("in_ready[%0d]", d), 16'(o_ir[d]), 16'(adv[d]));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                if (d == 0) q0.delete(); else q1.delete();
                chk($sformatf("rst_valid[%0d]", d), 16'(o_ov[d]), 16'h0);
                chk($sformatf("rst_sum[%0d]", d),   o_sum[d],      16'h0);
                chk($sformatf("rst_cout[%0d]", d),  16'(o_co[d]),  16'h0);
                chk($sformatf("rst_ovf[%0d]", d),   16'(o_of[d]),  16'h0);
            end else begin
                if (adv[d]) begin
                    e   = ref_op(wid(d), t_a[d], t_b[d], t_cin[d], t_sub[d]);
                    e.v = t_iv[d];
                    push(d, e);
                end
                xv = exp_valid(d);
                chk($sformatf("out_valid[%0d]", d), 16'(o_ov[d]), 16'(xv));
                if (xv) begin
                    f = front(d);
                    chk($sformatf("sum[%0d]", d),  o_sum[d],     f.s);
                    chk($sformatf("cout[%0d]", d), 16'(o_co[d]), 16'(f.c));
                    chk($sformatf("ovf[%0d]", d),  16'(o_of[d]), 16'(f.o));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle(0);
        idle(1);
        tick();
        tick();
        rst = 1'b0;

        // Basic add, latency 2.
        set(0, 1'b1, 16'h01, 16'h01, 1'b0, 1'b0, 1'b1);
        tick();
        idle(0);
        tick();
        chk("add_lat2_valid", 16'(o_ov[0]), 16'h1);
        chk("add_lat2_sum",   o_sum[0],     16'h0002);
        chk("add_lat2_cout",  16'(o_co[0]), 16'h0);
        tick();
        chk("add_one_beat", 16'(o_ov[0]), 16'h0);

        // Cross-slice carry, overflow and subtract, back to back.
        set(0, 1'b1, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b1); tick();
        set(0, 1'b1, 16'h0F, 16'h01, 1'b0, 1'b0, 1'b1); tick();
        chk("carry_ff_sum",  o_sum[0],     16'h0000);
        chk("carry_ff_cout", 16'(o_co[0]), 16'h1);
        set(0, 1'b1, 16'hAA, 16'h55, 1'b1, 1'b0, 1'b1); tick();
        chk("carry_0f_sum",  o_sum[0],     16'h0010);
        set(0, 1'b1, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b1); tick();
        chk("carry_aa_sum",  o_sum[0],     16'h0000);
        chk("carry_aa_cout", 16'(o_co[0]), 16'h1);
        set(0, 1'b1, 16'h05, 16'h07, 1'b0, 1'b1, 1'b1); tick();
        chk("ovf_7f_sum", o_sum[0],     16'h0080);
        chk("ovf_7f_ovf", 16'(o_of[0]), 16'h1);
        set(0, 1'b1, 16'h80, 16'h01, 1'b0, 1'b1, 1'b1); tick();
        chk("sub_57_sum",  o_sum[0],     16'h00FE);
        chk("sub_57_cout", 16'(o_co[0]), 16'h0);
        idle(0); tick();
        chk("sub_80_sum",  o_sum[0],     16'h007F);
        chk("sub_80_ovf",  16'(o_of[0]), 16'h1);
        chk("sub_80_cout", 16'(o_co[0]), 16'h1);
        tick();

        // Backpressure: stall three cycles once the first result appears.
        set(0, 1'b1, 16'h01, 16'h10, 1'b0, 1'b0, 1'b1); tick();
        set(0, 1'b1, 16'h02, 16'h10, 1'b0, 1'b0, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            set(0, 1'b1, 16'h03, 16'h10, 1'b0, 1'b0, 1'b0);
            tick();
            chk("stall_sum",   o_sum[0],     16'h0011);
            chk("stall_ready", 16'(o_ir[0]), 16'h0);
        end
        set(0, 1'b1, 16'h03, 16'h10, 1'b0, 1'b0, 1'b1); tick();
        chk("resume_sum", o_sum[0], 16'h0012);
        set(0, 1'b1, 16'h04, 16'h10, 1'b0, 1'b0, 1'b1); tick();
        idle(0);
        for (int i = 0; i < 3; i++) tick();

        // Bubbles: in_valid 1,0,1.
        set(0, 1'b1, 16'h21, 16'h02, 1'b0, 1'b0, 1'b1); tick();
        idle(0); tick();
        set(0, 1'b1, 16'h31, 16'h03, 1'b0, 1'b0, 1'b1); tick();
        idle(0);
        for (int i = 0; i < 3; i++) tick();

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++) begin
                set(d, 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0));
            end
            tick();
        end

        // Reset mid-stream with operations in flight.
        set(0, 1'b1, 16'h11, 16'h22, 1'b0, 1'b0, 1'b1);
        set(1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        idle(0);
        idle(1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_quiet", 16'(o_ov[0]), 16'h0);

        // Wide instance: latency 4, carry through every slice.
        set(1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1); tick();
        set(1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1); tick();
        idle(1);
        tick();
        chk("w16_early", 16'(o_ov[1]), 16'h0);
        tick();
        chk("w16_lat4_valid", 16'(o_ov[1]), 16'h1);
        chk("w16_lat4_sum",   o_sum[1],     16'h0002);
        tick();
        chk("w16_carry_sum",  o_sum[1],     16'h0000);
        chk("w16_carry_cout", 16'(o_co[1]), 16'h1);
        for (int i = 0; i < 4; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_rca.md
Name: pipelined_rca

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 8-bit combinational ripple_carry_adder.
- Splits a WIDTH-bit add into STAGES registered ripple slices, with the carry registered between slices.
- Adds a subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure.
- Sits in the datapath wherever a wide add must meet timing at one result per cycle.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 2.
- STAGES, 2, number of pipeline stages; must divide WIDTH; STAGES=1 gives a single registered full-width adder.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: add, 1: subtract
- in_valid  input  1  a/b/cin/sub valid this cycle
- in_ready  output  1  block accepts input this cycle
- sum  output  WIDTH  result
- cout  output  1  carry-out (sub: 1 = no borrow)
- ovf  output  1  signed overflow
- out_valid  output  1  sum/cout/ovf valid
- out_ready  input  1  downstream accepts result

Behaviour:
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + ~cin, i.e. a − b − cin, with cout=1 meaning no borrow.
  - ovf = signed overflow of the effective addition: carry into MSB XOR carry out of MSB.
- Slicing:
  - Slice width is SW = WIDTH/STAGES.
  - Stage k adds bits [k*SW +: SW] using the registered carry from stage k−1; stage 0 uses the effective carry-in.
  - Upper operand slices travel down the pipeline unmodified (input skew registers).
  - Lower sum slices are delayed to align with the final slice (output deskew).
- Pipeline control:
  - One global advance = !out_valid || out_ready.
  - When advance=1, every stage register and its valid bit load from the previous stage.
  - When advance=0, all stages hold and outputs stay stable.
- Input handshake:
  - in_ready = advance; this is combinational from out_valid/out_ready and does not depend on in_valid.
  - A transfer occurs when in_valid && in_ready.
  - When in_valid=0 and advance=1, a bubble (valid=0) enters stage 0.
- Latency and throughput:
  - A result is presented exactly STAGES cycles after acceptance, when there is no stall.
  - Throughput is 1 result/cycle; results leave strictly in order; none is lost or duplicated under stall.
- Output handshake: sum, cout and ovf are registered outputs and change only when advance=1.
- Reset:
  - sum=0, cout=0, ovf=0, out_valid=0, and all internal valid bits=0.
  - in_ready=1 in the cycle after reset is released.
  - Reset mid-stream discards all in-flight operations; nothing emerges afterwards.
- Boundaries:
  - Carry propagates across every slice boundary; e.g. 0xFF+0x01 carries through all slices.
  - Simultaneous out_ready=1 and new input while full: the output is consumed and the input accepted in the same cycle.
  - out_ready is ignored while out_valid=0.

Test Plan:
- Add (WIDTH=8, STAGES=2): a=0x01,b=0x01,cin=0,sub=0 -> 2 cycles later sum=0x02, cout=0, ovf=0, out_valid=1 for one cycle with out_ready=1.
- Cross-slice carry: a=0xFF,b=0x01 -> sum=0x00, cout=1, ovf=0; a=0x0F,b=0x01 -> sum=0x10, cout=0; a=0xAA,b=0x55,cin=1 -> sum=0x00, cout=1.
- Overflow and subtract:
  - a=0x7F,b=0x01 add -> sum=0x80, ovf=1.
  - a=0x05,b=0x07,sub=1,cin=0 -> sum=0xFE, cout=0.
  - a=0x80,b=0x01,sub=1 -> sum=0x7F, ovf=1, cout=1.
- Backpressure: stream a=1..4, b=0x10 back-to-back; hold out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 and sum held at 0x11 during the stall; results 0x11,0x12,0x13,0x14 arrive in order with none lost.
- Bubbles/throughput: alternate in_valid 1,0,1 -> out_valid follows the same pattern delayed by 2 cycles; continuous in_valid=1 with out_ready=1 -> one result per cycle.
- Reset mid-stream: assert rst with 2 operations in flight -> next cycle out_valid=0, sum=0, cout=0, ovf=0, and no stale result appears after release; repeat the first scenario with WIDTH=16, STAGES=4 -> same values with latency 4.
